// File: rtl/instr_src_pkg.sv
// Shared definitions for the instruction-source controller.
//   INSTR_W            : instruction word width
//   DEB_CYCLES_DEFAULT : debounce stability count used on hardware
//   src_state_t        : source-select FSM states
package instr_src_pkg;

  localparam int INSTR_W            = 12;
  localparam int DEB_CYCLES_DEFAULT = 250000;

  typedef enum logic [1:0] {
    S_MEM,
    S_EXT_WAIT,
    S_EXT_ISSUE
  } src_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle pulse on each debounced 0->1 edge.
//   clk      : system clock
//   reset    : synchronous, active-low reset
//   button_i : raw, bouncy button input
//   level_o  : debounced button level
//   press_o  : one-cycle pulse when level_o rises
module button_debouncer #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  output logic level_o,
  output logic press_o
);

  localparam int            CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_prev_q;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, so short glitches never get through.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= button_i;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/instr_source_ctrl.sv
// Instruction source selector placed ahead of the instruction register.
// Memory mode forwards mem_instr every cycle with PC advance enabled.
// External mode stalls the PC and issues the switch word once per
// debounced button press.
//   clk         : system clock
//   reset       : synchronous, active-low reset
//   left_button : raw issue button
//   is_external : 1 = switch instructions, 0 = memory instructions
//   sws         : switch instruction word
//   mem_instr   : instruction-memory read data
//   instr       : registered instruction to the instruction register
//   instr_valid : load/execute instr this cycle
//   pc_en       : PC may advance this cycle
//   ext_count   : number of external instructions issued (wraps)
module instr_source_ctrl
  import instr_src_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left_button,
  input  logic               is_external,
  input  logic [INSTR_W-1:0] sws,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               pc_en,
  output logic [CNT_W-1:0]   ext_count
);

  logic               press;
  logic               ext_s1_q, ext_sync_q;
  src_state_t         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               pc_en_q, pc_en_d;
  logic [CNT_W-1:0]   ext_count_q, ext_count_d;

  button_debouncer #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .reset    (reset),
    .button_i (left_button),
    .level_o  (),
    .press_o  (press)
  );

  // valid and pc_en default low, so every external-mode cycle stalls the PC
  // and an issue lasts exactly one cycle.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    pc_en_d       = 1'b0;
    ext_count_d   = ext_count_q;
    case (state_q)
      S_MEM: begin
        instr_d = mem_instr;
        if (ext_sync_q) begin
          state_d = S_EXT_WAIT;
        end else begin
          instr_valid_d = 1'b1;
          pc_en_d       = 1'b1;
        end
      end
      S_EXT_WAIT: begin
        // A press beats a simultaneous mode drop: the issue still happens.
        if (press) begin
          instr_d       = sws;
          instr_valid_d = 1'b1;
          ext_count_d   = ext_count_q + 1'b1;
          state_d       = S_EXT_ISSUE;
        end else if (!ext_sync_q) begin
          state_d = S_MEM;
        end
      end
      S_EXT_ISSUE: begin
        // Presses arriving here are dropped, not queued.
        state_d = ext_sync_q ? S_EXT_WAIT : S_MEM;
      end
      default: state_d = S_MEM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ext_s1_q      <= 1'b0;
      ext_sync_q    <= 1'b0;
      state_q       <= S_MEM;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_en_q       <= 1'b0;
      ext_count_q   <= '0;
    end else begin
      ext_s1_q      <= is_external;
      ext_sync_q    <= ext_s1_q;
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_en_q       <= pc_en_d;
      ext_count_q   <= ext_count_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc_en       = pc_en_q;
  assign ext_count   = ext_count_q;

endmodule

// File: tb/tb_instr_source_ctrl.sv
// Bench for instr_source_ctrl with a short debounce window. Each external
// issue expected by a test is queued when the press is driven; a monitor
// pops and compares whenever the DUT produces an external issue.
module tb_instr_source_ctrl;

  localparam int DEB = 4;
  // 2 synchronizer edges + DEB-1 counting edges + toggle edge + output register
  localparam int ISSUE_LAT = DEB + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        left_button;
  logic        is_external;
  logic [11:0] sws;
  logic [11:0] mem_instr;
  logic [11:0] instr;
  logic        instr_valid;
  logic        pc_en;
  logic [7:0]  ext_count;

  typedef struct packed {
    logic [11:0] instr;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       sb_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         issues      = 0;
  logic [7:0] exp_count   = 8'd0;

  always #5 clk = ~clk;

  instr_source_ctrl #(
    .DEB_CYCLES (DEB),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .left_button (left_button),
    .is_external (is_external),
    .sws         (sws),
    .mem_instr   (mem_instr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_en       (pc_en),
    .ext_count   (ext_count)
  );

  // Monitor: invariant every cycle, scoreboard pop on each external issue.
  always @(negedge clk) begin
    exp_t e;
    vectors++;
    if (pc_en === 1'b1 && instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL invariant: pc_en=%b instr_valid=%b", pc_en, instr_valid);
    end
    if (instr_valid === 1'b1 && pc_en === 1'b0) begin
      issues++;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_issue: instr=%h ext_count=%0d, none expected", instr, ext_count);
      end else begin
        e = sb_q.pop_front();
        if (instr !== e.instr || ext_count !== e.cnt) begin
          miscompares++;
          $display("FAIL issue: got instr=%h count=%0d, want instr=%h count=%0d",
                   instr, ext_count, e.instr, e.cnt);
        end
      end
    end
  end

  task automatic expect_issue(input logic [11:0] val);
    exp_t e;
    exp_count++;
    e.instr = val;
    e.cnt   = exp_count;
    sb_q.push_back(e);
  endtask

  task automatic press_button(input logic [11:0] val, input int hold);
    sws = val;
    expect_issue(val);
    left_button = 1'b1;
    repeat (hold) @(negedge clk);
    left_button = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    is_external = 1'b0;
    left_button = 1'b0;
    sws         = 12'h000;
    mem_instr   = 12'hA5C;
    repeat (3) @(negedge clk);
    vectors++;
    if ({instr, instr_valid, pc_en, ext_count} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_state: instr=%h valid=%b pc_en=%b count=%0d, want all 0",
               instr, instr_valid, pc_en, ext_count);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (instr !== 12'hA5C || instr_valid !== 1'b1 || pc_en !== 1'b1) begin
      miscompares++;
      $display("FAIL first_mem: instr=%h valid=%b pc_en=%b, want a5c 1 1",
               instr, instr_valid, pc_en);
    end
  endtask

  task automatic test_mem_mode();
    logic [11:0] vals [4] = '{12'h123, 12'hFFF, 12'h000, 12'h8E1};
    for (int i = 0; i < 4; i++) begin
      mem_instr = vals[i];
      @(negedge clk);
      vectors++;
      if (instr !== vals[i] || instr_valid !== 1'b1 || pc_en !== 1'b1) begin
        miscompares++;
        $display("FAIL mem_mode[%0d]: instr=%h valid=%b pc_en=%b, want %h 1 1",
                 i, instr, instr_valid, pc_en, vals[i]);
      end
    end
  endtask

  task automatic test_clean_press();
    int   i0;
    logic pc_seen;
    is_external = 1'b1;
    sws         = 12'h3F1;
    repeat (5) @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0 || pc_en !== 1'b0) begin
      miscompares++;
      $display("FAIL ext_wait: valid=%b pc_en=%b, want 0 0", instr_valid, pc_en);
    end
    i0      = issues;
    pc_seen = 1'b0;
    expect_issue(12'h3F1);
    left_button = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pc_en !== 1'b0) pc_seen = 1'b1;
    end
    left_button = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pc_en !== 1'b0) pc_seen = 1'b1;
    end
    vectors++;
    if (pc_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL ext_pc_en: pc_en seen high=%b, want 0", pc_seen);
    end
    vectors++;
    if (issues - i0 != 1) begin
      miscompares++;
      $display("FAIL held_press: issues=%0d, want 1", issues - i0);
    end
    vectors++;
    if (ext_count !== 8'd1) begin
      miscompares++;
      $display("FAIL count_after_press: ext_count=%0d, want 1", ext_count);
    end
  endtask

  task automatic test_bounce();
    int   i0;
    int   lat;
    logic found;
    sws = 12'h5A5;
    i0  = issues;
    for (int i = 0; i < 4; i++) begin
      left_button = (i % 2 == 0);
      @(negedge clk);
    end
    left_button = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (issues != i0) begin
      miscompares++;
      $display("FAIL glitch_only: issues=%0d, want 0", issues - i0);
    end
    for (int i = 0; i < 4; i++) begin
      left_button = (i % 2 == 0);
      @(negedge clk);
    end
    expect_issue(12'h5A5);
    left_button = 1'b1;
    found = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && pc_en === 1'b0) begin
        found = 1'b1;
        lat   = k;
      end
    end
    vectors++;
    if (!found || lat != ISSUE_LAT) begin
      miscompares++;
      $display("FAIL bounce_latency: found=%b latency=%0d, want 1 %0d", found, lat, ISSUE_LAT);
    end
    repeat (5) @(negedge clk);
    left_button = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (issues - i0 != 1) begin
      miscompares++;
      $display("FAIL bounce_count: issues=%0d, want 1", issues - i0);
    end
  endtask

  task automatic test_press_and_drop();
    logic found;
    logic resumed;
    sws       = 12'h0FF;
    mem_instr = 12'hC3A;
    expect_issue(12'h0FF);
    left_button = 1'b1;
    repeat (4) @(negedge clk);
    // Mode drop timed to reach the FSM in the same cycle as the press pulse.
    is_external = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && pc_en === 1'b0) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL drop_issue: issue seen=%b, want 1", found);
    end
    resumed = 1'b0;
    for (int k = 0; k < 3 && !resumed; k++) begin
      @(negedge clk);
      if (pc_en === 1'b1) resumed = 1'b1;
    end
    vectors++;
    if (!resumed || instr !== 12'hC3A || instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_resume: pc_en=%b instr=%h valid=%b, want 1 c3a 1",
               pc_en, instr, instr_valid);
    end
    left_button = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [11:0] v;
    is_external = 1'b1;
    repeat (5) @(negedge clk);
    do begin
      v = 12'($urandom);
      press_button(v, 8);
    end while (exp_count != 8'd0);
    vectors++;
    if (ext_count !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap: ext_count=%0d, want 0", ext_count);
    end
  endtask

  task automatic test_reset_mid_issue();
    logic found;
    sws = 12'h7E7;
    expect_issue(12'h7E7);
    left_button = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && pc_en === 1'b0) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL pre_reset_issue: issue seen=%b, want 1", found);
    end
    reset       = 1'b0;
    is_external = 1'b0;
    mem_instr   = 12'h246;
    @(negedge clk);
    exp_count = 8'd0;
    vectors++;
    if ({instr, instr_valid, pc_en, ext_count} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_mid_issue: instr=%h valid=%b pc_en=%b count=%0d, want all 0",
               instr, instr_valid, pc_en, ext_count);
    end
    left_button = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    vectors++;
    if (instr !== 12'h246 || instr_valid !== 1'b1 || pc_en !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_mem: instr=%h valid=%b pc_en=%b, want 246 1 1",
               instr, instr_valid, pc_en);
    end
  endtask

  initial begin
    test_reset();
    test_mem_mode();
    test_clean_press();
    test_bounce();
    test_press_and_drop();
    test_wrap();
    test_reset_mid_issue();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_issues: %0d expected issues never seen, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_source_ctrl.md
Name: instr_source_ctrl

Overview:
Upstream of the instruction register and mips core. Selects each cycle between the instruction-memory word and a switch-entered instruction. In external mode, it issues one switch instruction per debounced button press and stalls PC advance. Outputs are registered; the instruction register loads `instr` when `instr_valid` is high.

Parameters:
INSTR_W, 12, instruction width
DEB_CYCLES, 250000, consecutive stable samples required to accept a button level (4 in simulation)
CNT_W, 8, width of the external-issue counter

Ports:
clk  input  1  system clock (divided clock domain)
reset  input  1  synchronous, active-low reset
left_button  input  1  raw, bouncy push-button
is_external  input  1  mode select: 1 = switch instructions, 0 = memory instructions
sws  input  INSTR_W  switch instruction word
mem_instr  input  INSTR_W  instruction-memory read data
instr  output  INSTR_W  instruction to the instruction register
instr_valid  output  1  instr is to be loaded and executed this cycle
pc_en  output  1  PC may advance this cycle
ext_count  output  CNT_W  number of external instructions issued

Behaviour:
- Reset: sampled on rising clk while reset==0.
  - Reset values: instr=0, instr_valid=0, pc_en=0, ext_count=0, state=S_MEM.
  - Synchronizer and debouncer counter cleared; debounced level=0.
  - Reset mid-issue discards the pending issue.
- Synchronization:
  - left_button and is_external each pass through a 2-flop synchronizer.
  - is_external is not debounced.
- Debounce:
  - A counter increments while the synced button differs from the debounced level, and clears when they match.
  - When the counter reaches DEB_CYCLES-1 with a differing sample, the debounced level toggles.
  - Glitches shorter than DEB_CYCLES are ignored.
- press: one-cycle pulse on a 0->1 transition of the debounced level.
  - A held button yields exactly one press.
- FSM:
  - S_MEM:
    - instr<=mem_instr, instr_valid<=1, pc_en<=1 (1-cycle latency).
    - If ext_sync==1: next state S_EXT_WAIT; instr_valid<=0, pc_en<=0 on that same edge.
  - S_EXT_WAIT:
    - instr holds, instr_valid<=0, pc_en<=0.
    - On press: instr<=sws (sampled that cycle), instr_valid<=1, ext_count<=ext_count+1, next state S_EXT_ISSUE.
    - Else if ext_sync==0: next state S_MEM.
    - Press and mode drop in the same cycle: press wins.
  - S_EXT_ISSUE:
    - instr_valid<=0, pc_en<=0; instr holds.
    - Next state S_EXT_WAIT if ext_sync, else S_MEM.
    - A press in this cycle is dropped; presses are not queued.
- instr_valid is high for exactly one cycle per external issue.
- pc_en is never high in external mode, so memory execution resumes at the stalled PC.
- ext_count wraps 2^CNT_W-1 -> 0.
- Invariant: pc_en==1 implies instr_valid==1.

Decomposition:
- Package instr_src_pkg holds:
  - typedef enum logic [1:0] {S_MEM, S_EXT_WAIT, S_EXT_ISSUE} src_state_t;
  - INSTR_W=12 and the default DEB_CYCLES.
- One sub-module, button_debouncer:
  - Contains the 2-flop synchronizer, stability counter, debounced level and rising-edge pulse.
  - Outputs: level, press.

Test Plan:
- Reset, then is_external=0, mem_instr=12'hA5C -> one cycle later instr=12'hA5C, instr_valid=1, pc_en=1; during reset all outputs 0.
- DEB_CYCLES=4, is_external=1, sws=12'h3F1:
  - Apply a clean press held 20 cycles.
  - Required: exactly one instr_valid pulse with instr=12'h3F1, ext_count=1, pc_en=0 throughout.
- Bounce pattern 1,0,1,0 in single cycles, then a stable 1 -> exactly one issue, occurring DEB_CYCLES+sync cycles after the stable edge; no issue from the glitches.
- In S_EXT_WAIT, drop is_external in the same cycle as press with sws=12'h0FF:
  - Required: issue of 12'h0FF.
  - Then S_MEM, with instr=mem_instr and pc_en=1 from the following cycle.
- Issue 256 presses -> ext_count returns to 0.
- Assert reset while in S_EXT_ISSUE -> next cycle instr=0, instr_valid=0, ext_count=0, state S_MEM.
